// File: rtl/serial_word_tx.sv
// Framed parallel-to-serial transmitter: start bit, LSB-first data, even parity, stop bit.
// A one-word holding register lets consecutive frames run with no idle gap on the line.
module serial_word_tx #(
  parameter int WIDTH = 32,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_o,
  output logic             busy,
  output logic             frame_done
);

  // state  | meaning
  // IDLE   | line high, waiting for a held word
  // START  | start bit (low) for DIV cycles
  // DATA   | WIDTH data bits, LSB first, DIV cycles each
  // PARITY | even-parity bit for DIV cycles
  // STOP   | stop bit (high); chains to START when a word is held
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int BW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic bit_end;
  logic last_bit;
  logic accept;
  logic load;

  // bit_end marks the final cycle of every serial bit period
  generate
    if (DIV > 1) begin : g_div
      localparam int DW = $clog2(DIV);
      logic [DW-1:0] div_cnt_q, div_cnt_d;

      always_comb begin
        if (state_q == IDLE || div_cnt_q == '0) div_cnt_d = DW'(DIV - 1);
        else                                     div_cnt_d = div_cnt_q - DW'(1);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
      end

      assign bit_end = (div_cnt_q == '0);
    end else begin : g_nodiv
      assign bit_end = 1'b1;
    end
  endgenerate

  assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));
  assign accept   = in_valid && !hold_full_q;
  assign load     = hold_full_q && ((state_q == IDLE) || (state_q == STOP && bit_end));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_full_q)         state_d = START;
      START:   if (bit_end)             state_d = DATA;
      DATA:    if (bit_end && last_bit) state_d = PARITY;
      PARITY:  if (bit_end)             state_d = STOP;
      STOP:    if (bit_end)             state_d = hold_full_q ? START : IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Line outputs are registered, so the wire trails the state register by one cycle
  always_comb begin
    ser_d  = 1'b1;
    busy_d = (state_q != IDLE);
    done_d = (state_q == STOP) && bit_end;
    case (state_q)
      START:   ser_d = 1'b0;
      DATA:    ser_d = shift_q[0];
      PARITY:  ser_d = par_q;
      default: ser_d = 1'b1;
    endcase
  end

  always_comb begin
    hold_d      = accept ? in_data : hold_q;
    hold_full_d = accept || (hold_full_q && !load);

    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;

    if (load) begin
      shift_d = hold_q;
      par_d   = 1'b0;
    end else if (state_q == DATA && bit_end) begin
      shift_d = shift_q >> 1;
      par_d   = par_q ^ shift_q[0];
    end

    if (state_q != DATA)  bit_cnt_d = '0;
    else if (bit_end)     bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      ser_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_q       <= ser_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready   = !hold_full_q;
  assign ser_o      = ser_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: two WIDTH=8 instances, DIV=1 (d1) and DIV=2 (d2).
// Expected line sequences are written out by hand as start/data/parity/stop bits.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       rst1_n, rst2_n;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       rdy1, rdy2, ser1, ser2, busy1, busy2, done1, done2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(8), .DIV(1)) u_d1 (
    .clk(clk), .reset(rst1_n), .in_data(data1), .in_valid(valid1),
    .in_ready(rdy1), .ser_o(ser1), .busy(busy1), .frame_done(done1)
  );

  serial_word_tx #(.WIDTH(8), .DIV(2)) u_d2 (
    .clk(clk), .reset(rst2_n), .in_data(data2), .in_valid(valid2),
    .in_ready(rdy2), .ser_o(ser2), .busy(busy2), .frame_done(done2)
  );

  typedef struct {
    bit         sel;   // 0: d1 (DIV=1), 1: d2 (DIV=2)
    logic [7:0] data;
    logic [10:0] seq;  // line bits in transmit order, leftmost first
  } vec_t;

  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ser_of(input bit sel);
    return sel ? ser2 : ser1;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy2 : busy1;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done2 : done1;
  endfunction
  function automatic logic rdy_of(input bit sel);
    return sel ? rdy2 : rdy1;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin valid2 = v; data2 = d; end
    else     begin valid1 = v; data1 = d; end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  // mode 0: valid low while waiting, 1: valid high holding w, 2: valid high with junk data
  task automatic push(input bit sel, input logic [7:0] w, input int mode);
    int n = 0;
    while (!rdy_of(sel) && n < 400) begin
      case (mode)
        0:       drive(sel, 1'b0, 8'h00);
        1:       drive(sel, 1'b1, w);
        default: drive(sel, 1'b1, 8'($urandom));
      endcase
      @(negedge clk);
      n++;
    end
    chk1("in_ready_wait", rdy_of(sel), 1'b1);
    drive(sel, 1'b1, w);
    @(negedge clk);
    chk1("in_ready_drop", rdy_of(sel), 1'b0);
  endtask

  // Checks nf contiguous frames cycle by cycle, then one idle cycle.
  task automatic expect_frames(input bit sel, input int div, input int nf,
                               input logic [32:0] seq, input bit wait_low);
    int n;
    int flen;
    int total;
    int slot;
    flen  = 11 * div;
    total = nf * flen;
    if (wait_low) begin
      n = 0;
      while (ser_of(sel) !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk1("start_seen", ser_of(sel), 1'b0);
    end else begin
      @(negedge clk);
    end
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      slot = c / div;
      chk1("ser", ser_of(sel), seq[nf*11 - 1 - slot]);
      chk1("busy", busy_of(sel), 1'b1);
      chk1("frame_done", done_of(sel), (c % flen) == flen - 1);
    end
    @(negedge clk);
    chk1("idle_ser", ser_of(sel), 1'b1);
    chk1("idle_busy", busy_of(sel), 1'b0);
    chk1("idle_done", done_of(sel), 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 11'b01010010101};
    vecs[1] = '{1'b0, 8'h01, 11'b01000000011};
    vecs[2] = '{1'b0, 8'hFF, 11'b01111111101};
    vecs[3] = '{1'b0, 8'h00, 11'b00000000001};
    vecs[4] = '{1'b0, 8'h3C, 11'b00011110001};
    vecs[5] = '{1'b1, 8'h80, 11'b00000000111};

    // Reset held with a word already valid on d1
    rst1_n = 1'b0; rst2_n = 1'b0;
    valid1 = 1'b1; data1 = 8'hFF;
    valid2 = 1'b0; data2 = 8'h00;
    repeat (2) @(negedge clk);
    chk1("rst_ser1",  ser1,  1'b1);
    chk1("rst_busy1", busy1, 1'b0);
    chk1("rst_rdy1",  rdy1,  1'b1);
    chk1("rst_done1", done1, 1'b0);
    chk1("rst_ser2",  ser2,  1'b1);
    chk1("rst_rdy2",  rdy2,  1'b1);
    rst1_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    chk1("rst_first_accept", rdy1, 1'b0);
    drive(0, 1'b0, 8'h00);
    expect_frames(0, 1, 1, {22'b0, 11'b01111111101}, 1'b1);

    // Single frames with exact handshake-to-start latency
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].sel, vecs[i].data, 0);
      drive(vecs[i].sel, 1'b0, 8'h00);
      chk1("lat_ser_t",  ser_of(vecs[i].sel),  1'b1);
      chk1("lat_busy_t", busy_of(vecs[i].sel), 1'b0);
      @(negedge clk);
      chk1("lat_rdy_t1",  rdy_of(vecs[i].sel),  1'b1);
      chk1("lat_ser_t1",  ser_of(vecs[i].sel),  1'b1);
      chk1("lat_busy_t1", busy_of(vecs[i].sel), 1'b0);
      expect_frames(vecs[i].sel, vecs[i].sel ? 2 : 1, 1, {22'b0, vecs[i].seq}, 1'b0);
    end

    // Back-to-back: 0xFF then 0x00 with valid held continuously
    fork
      begin
        push(0, 8'hFF, 1);
        push(0, 8'h00, 1);
        drive(0, 1'b0, 8'h00);
      end
      expect_frames(0, 1, 2, {11'b0, 11'b01111111101, 11'b00000000001}, 1'b1);
    join

    // Backpressure: junk data with valid high while in_ready is low
    fork
      begin
        push(0, 8'h01, 0);
        push(0, 8'hA5, 2);
        push(0, 8'h3C, 2);
        drive(0, 1'b0, 8'h00);
      end
      expect_frames(0, 1, 3, {11'b01000000011, 11'b01010010101, 11'b00011110001}, 1'b1);
    join

    // Mid-frame asynchronous reset on d2 with a second word held
    push(1, 8'hA5, 0);
    drive(1, 1'b0, 8'h00);
    push(1, 8'h3C, 0);
    drive(1, 1'b0, 8'h00);
    repeat (6) @(negedge clk);
    chk1("mid_busy", busy2, 1'b1);
    @(posedge clk);
    #3;
    rst2_n = 1'b0;
    #1;
    chk1("mid_rst_ser",  ser2,  1'b1);
    chk1("mid_rst_busy", busy2, 1'b0);
    chk1("mid_rst_rdy",  rdy2,  1'b1);
    chk1("mid_rst_done", done2, 1'b0);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk1("post_rst_ser",  ser2,  1'b1);
      chk1("post_rst_busy", busy2, 1'b0);
      chk1("post_rst_done", done2, 1'b0);
    end
    chk1("post_rst_rdy", rdy2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
